chain_monitor: RTL and testbench

CHAIN_MONITOR -- requirements
Module: chain_monitor

---
 rtl/chain_monitor_pkg.sv | 25 ++
 rtl/chain_monitor_fifo.sv | 58 +++++
 rtl/chain_monitor.sv | 157 +++++++++++++++
 tb/tb_chain_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chain_monitor_pkg.sv
// chain_monitor_pkg: state encoding, record layout and default constants.
// X checking is compiled in only when CHAIN_MONITOR_XCHK_EN is defined.
package chain_monitor_pkg;

  localparam int DEF_N_STAGES      = 5;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_TS_W          = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2
  } state_e;

  // Record layout at default widths; the top rebuilds it at its own widths.
  typedef struct packed {
    logic [DEF_N_STAGES-1:0] mask;
    logic [DEF_TS_W-1:0]     ts;
    logic                    x;
  } rec_t;

  localparam int DEF_REC_W = $bits(rec_t);

endpackage

// File: rtl/chain_monitor_fifo.sv
// chain_monitor_fifo: error-record FIFO with register-derived valid.
// Optional X checking of the parent is selected by CHAIN_MONITOR_XCHK_EN.
module chain_monitor_fifo
  import chain_monitor_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_REC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign o_valid = (r_cnt != '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = o_valid & i_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/chain_monitor.sv
// chain_monitor: settles on the observed chain, checks inversion, logs errors.
// Define CHAIN_MONITOR_XCHK_EN to flag X/Z stage values as errors.
module chain_monitor
  import chain_monitor_pkg::*;
#(
  parameter int N_STAGES      = DEF_N_STAGES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int TS_W          = DEF_TS_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  input  logic [N_STAGES-1:0] out,
  output logic                err_valid,
  input  logic                err_ready,
  output logic [N_STAGES-1:0] err_mask,
  output logic [TS_W-1:0]     err_ts,
  output logic                err_x,
  output logic [15:0]         mismatch_cnt,
  output logic                overflow,
  output logic                busy
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [N_STAGES-1:0] mask;
    logic [TS_W-1:0]     ts;
    logic                x;
  } mon_rec_t;

  logic [N_STAGES:0]   w_cur;
  logic [N_STAGES:0]   r_prev;
  logic                w_change;
  state_e              r_state;
  state_e              w_next;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt;
  logic [TS_W-1:0]     r_ts;
  logic [N_STAGES-1:0] w_exp;
  logic [N_STAGES-1:0] w_diff;
  logic [N_STAGES-1:0] w_mask;
  logic                w_x;
  logic                w_push;
  logic                w_drop;
  logic [15:0]         r_mm;
  logic                r_ovf;
  mon_rec_t            w_rec_in;
  mon_rec_t            w_rec_out;

  assign w_cur = {in, out};

`ifdef CHAIN_MONITOR_XCHK_EN
  logic [N_STAGES-1:0] w_xbit;

  assign w_change = (w_cur !== r_prev);

  always_comb begin
    w_xbit    = '0;
    w_xbit[0] = $isunknown({in, out[0]});
    for (int i = 1; i < N_STAGES; i++) begin
      w_xbit[i] = $isunknown(out[i -: 2]);
    end
  end

  assign w_mask = (r_state == S_CHECK) ? (w_diff | w_xbit) : '0;
  assign w_x    = |w_xbit;
`else
  assign w_change = (w_cur != r_prev);
  assign w_mask   = (r_state == S_CHECK) ? w_diff : '0;
  assign w_x      = 1'b0;
`endif

  // Each stage must invert whatever actually drives it.
  always_comb begin
    w_exp    = '0;
    w_exp[0] = ~in;
    for (int i = 1; i < N_STAGES; i++) begin
      w_exp[i] = ~out[i-1];
    end
  end

  assign w_diff = out ^ w_exp;
  assign w_push = |w_mask;

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_change) begin
          w_next = S_SETTLE;
          w_cnt  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (w_change)            w_cnt  = SETTLE_LD;
        else if (r_cnt == 8'd0)  w_next = S_CHECK;
        else                     w_cnt  = r_cnt - 8'd1;
      end
      S_CHECK: begin
        if (w_change) begin
          w_next = S_SETTLE;
          w_cnt  = SETTLE_LD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= w_cur;
      r_ts    <= '0;
      r_mm    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_prev  <= w_cur;
      r_ts    <= r_ts + TS_W'(1);
      if (w_push && (r_mm != 16'hFFFF)) r_mm <= r_mm + 16'd1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign w_rec_in.mask = w_mask;
  assign w_rec_in.ts   = r_ts;
  assign w_rec_in.x    = w_x;

  chain_monitor_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(mon_rec_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_rec_in),
    .i_ready (err_ready),
    .o_valid (err_valid),
    .o_data  (w_rec_out),
    .o_drop  (w_drop)
  );

  assign err_mask     = w_rec_out.mask;
  assign err_ts       = w_rec_out.ts;
  assign err_x        = w_rec_out.x;
  assign mismatch_cnt = r_mm;
  assign overflow     = r_ovf;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_chain_monitor.sv
// tb_chain_monitor: directed and random stimulus against a window-based model.
// Model: a check happens SC+1 cycles after a change followed by SC quiet cycles.
module tb_chain_monitor;

  localparam int SC    = 4;
  localparam int NS    = 5;
  localparam int DEPTH = 8;

  logic        clk   = 1'b0;
  logic        r_rst = 1'b1;
  logic        r_in  = 1'b0;
  logic [4:0]  r_out = 5'b10101;
  logic        r_rdy = 1'b0;
  logic        w_valid;
  logic [4:0]  w_mask;
  logic [15:0] w_ts;
  logic        w_x;
  logic [15:0] w_mm;
  logic        w_ovf;
  logic        w_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  m;
    logic [15:0] ts;
  } mrec_t;

  mrec_t       q[$];
  logic [5:0]  m_prev = '0;
  logic [SC:0] m_hist = '0;
  logic [15:0] m_ts   = '0;
  logic [15:0] m_cnt  = '0;
  logic        m_ovf  = 1'b0;
  logic [15:0] mm_base;

  chain_monitor #(
    .N_STAGES      (NS),
    .SETTLE_CYCLES (SC),
    .FIFO_DEPTH    (DEPTH),
    .TS_W          (16)
  ) u_dut (
    .clk          (clk),
    .reset        (r_rst),
    .in           (r_in),
    .out          (r_out),
    .err_valid    (w_valid),
    .err_ready    (r_rdy),
    .err_mask     (w_mask),
    .err_ts       (w_ts),
    .err_x        (w_x),
    .mismatch_cnt (w_mm),
    .overflow     (w_ovf),
    .busy         (w_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] good_out(input logic iv);
    logic [4:0] r;
    logic       s;
    s = iv;
    for (int k = 0; k < NS; k++) begin
      r[k] = ~s;
      s    = r[k];
    end
    return r;
  endfunction

  function automatic logic [4:0] chain_fail(input logic iv, input logic [4:0] o);
    logic [4:0] f;
    logic       s;
    s = iv;
    for (int k = 0; k < NS; k++) begin
      f[k] = (o[k] == s);
      s    = o[k];
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [4:0] ov, input logic rdy, input logic rst);
    logic [5:0] cur;
    logic [4:0] m;
    logic       due;
    mrec_t      rec;
    r_in  = iv;
    r_out = ov;
    r_rdy = rdy;
    r_rst = rst;
    @(posedge clk);
    #1;
    cur = {iv, ov};
    if (rst) begin
      m_prev = cur;
      m_hist = '0;
      m_ts   = '0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
      q.delete();
    end else begin
      due = m_hist[SC] && (m_hist[SC-1:0] == '0);
      m   = chain_fail(iv, ov);
      if ((q.size() != 0) && rdy) rec = q.pop_front();
      if (due && (m != '0)) begin
        rec.m  = m;
        rec.ts = m_ts;
        if (q.size() < DEPTH) q.push_back(rec);
        else m_ovf = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      m_ts++;
      m_hist = {m_hist[SC-1:0], (cur != m_prev)};
      m_prev = cur;
    end
    chk("valid", w_valid, q.size() != 0);
    chk("mask", w_mask, (q.size() != 0) ? q[0].m : 5'd0);
    chk("ts", w_ts, (q.size() != 0) ? q[0].ts : 16'd0);
    chk("x", w_x, 1'b0);
    chk("mcnt", w_mm, m_cnt);
    chk("ovf", w_ovf, m_ovf);
    chk("busy", w_busy, |m_hist);
  endtask

  task automatic hold(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(r_in, r_out, rdy, 1'b0);
  endtask

  initial begin
    logic       iv;
    logic [4:0] ov;
    int         r;

    for (int k = 0; k < 3; k++) step(1'b0, 5'b10101, 1'b0, 1'b1);
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_busy", w_busy, 1'b0);
    chk("rst_mcnt", w_mm, 16'd0);
    hold(3, 1'b0);

    for (int t = 0; t < 4; t++) begin
      iv = ~r_in;
      step(iv, r_out, 1'b0, 1'b0);
      step(iv, r_out ^ 5'b00001, 1'b0, 1'b0);
      step(iv, good_out(iv), 1'b0, 1'b0);
      hold(8, 1'b0);
    end
    chk("good_mcnt", w_mm, 16'd0);
    chk("good_valid", w_valid, 1'b0);

    step(1'b1, 5'b11010, 1'b0, 1'b0);
    hold(5, 1'b0);
    chk("stuck_valid", w_valid, 1'b1);
    chk("stuck_mask", w_mask, 5'b10000);
    chk("stuck_ts", w_ts, m_ts - 16'd1);

    for (int t = 0; t < 10; t++) begin
      iv = ~r_in;
      step(iv, good_out(iv), 1'b1, 1'b0);
      chk("tog_busy", w_busy, 1'b1);
      hold(1, 1'b1);
      chk("tog_busy", w_busy, 1'b1);
    end
    hold(8, 1'b1);
    chk("tog_idle", w_busy, 1'b0);

    mm_base = m_cnt;
    for (int e = 0; e < 9; e++) begin
      iv = ~r_in;
      step(iv, good_out(iv) ^ 5'b10000, 1'b0, 1'b0);
      hold(5, 1'b0);
    end
    chk("ovf_set", w_ovf, 1'b1);
    chk("ovf_mcnt", w_mm, mm_base + 16'd9);
    iv = ~r_in;
    step(iv, good_out(iv) ^ 5'b01000, 1'b0, 1'b0);
    hold(4, 1'b0);
    hold(1, 1'b1);
    hold(12, 1'b1);

    for (int e = 0; e < 3; e++) begin
      iv = ~r_in;
      step(iv, good_out(iv) ^ 5'b00010, 1'b0, 1'b0);
      hold(5, 1'b0);
    end
    chk("pend_valid", w_valid, 1'b1);
    step(~r_in, 5'b00000, 1'b0, 1'b1);
    chk("prst_valid", w_valid, 1'b0);
    chk("prst_mcnt", w_mm, 16'd0);
    chk("prst_ovf", w_ovf, 1'b0);
    hold(10, 1'b1);
    chk("prst_none", w_mm, 16'd0);

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      iv = r_in;
      ov = r_out;
      if (r == 0) begin
        iv = ~r_in;
        ov = good_out(iv);
      end else if (r == 1) begin
        iv = 1'($urandom);
        ov = 5'($urandom);
      end
      step(iv, ov, 1'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
